// File: rtl/data_packer_pkg.sv
// Shared types and constants for the data_packer trace stage.
package data_packer_pkg;

  localparam int unsigned N          = 8;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned MAX_CHAINS = 4;
  localparam int unsigned CHAIN_W    = $clog2(MAX_CHAINS);
  localparam int unsigned IDX_W      = $clog2(N);
  localparam int unsigned LANES_W    = $clog2(N) + 1;

  // Firmware mode byte bit positions
  localparam int unsigned MODE_SCALAR_BIT = 0;
  localparam int unsigned MODE_FLUSH_BIT  = 1;

  typedef logic [DATA_WIDTH-1:0] lane_t;
  typedef logic [7:0]            mode_t;
  typedef lane_t [N-1:0]         vec_t;

endpackage

// File: rtl/data_packer_if.sv
// Vector stream bus between the ALU, the packer and the trace buffer.
interface data_packer_if;
  import data_packer_pkg::*;

  logic               valid_in;
  logic [1:0]         eof_in;
  logic [1:0]         bof_in;
  logic [CHAIN_W-1:0] chainId_in;
  vec_t               vector_in;

  vec_t               vector_out;
  logic               valid_out;
  logic [CHAIN_W-1:0] chainId_out;
  logic [1:0]         eof_out;
  logic [LANES_W-1:0] lanes_out;

  modport slave (
    input  valid_in, eof_in, bof_in, chainId_in, vector_in,
    output vector_out, valid_out, chainId_out, eof_out, lanes_out
  );

  modport master (
    output valid_in, eof_in, bof_in, chainId_in, vector_in,
    input  vector_out, valid_out, chainId_out, eof_out, lanes_out
  );

endinterface

// File: rtl/data_packer_config_byte_loader.sv
// Sequential firmware byte loader: consecutive bytes addressed to CONFIG_ID
// fill a register array in order; extra bytes are ignored.
module config_byte_loader #(
  parameter int unsigned NUM_REGS  = 4,
  parameter logic [7:0]  CONFIG_ID = 8'd0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable_i,
  input  logic [7:0]               config_id_i,
  input  logic [7:0]               config_data_i,
  output logic [NUM_REGS-1:0][7:0] regs_o
);

  localparam int unsigned REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [7:0]               cnt_q, cnt_d;
  logic [NUM_REGS-1:0][7:0] regs_q, regs_d;

  // Next-state: write addressed byte, advance saturating counter, else rewind
  always_comb begin
    cnt_d  = '0;
    regs_d = regs_q;
    if (enable_i && (config_id_i == CONFIG_ID)) begin
      if (32'(cnt_q) < NUM_REGS) begin
        regs_d[cnt_q[REG_IDX_W-1:0]] = config_data_i;
      end
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      regs_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      regs_q <= regs_d;
    end
  end

  assign regs_o = regs_q;

endmodule

// File: rtl/data_packer.sv
// Trace-path packer: passes whole ALU vectors or packs lane 0 of successive
// vectors into dense N-lane words, per firmware-selected chain mode.
// Optional drop counter enabled by macro DATA_PACKER_DROP_CNT_EN.
module data_packer
  import data_packer_pkg::*;
#(
  parameter logic [7:0] PERSONAL_CONFIG_ID = 8'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tracing,
  input  logic [7:0]        configId,
  input  logic [7:0]        configData,
  data_packer_if.slave      bus
`ifdef DATA_PACKER_DROP_CNT_EN
  ,
  output logic [15:0]       drop_count
`endif
);

  mode_t [MAX_CHAINS-1:0] modes;

  config_byte_loader #(
    .NUM_REGS  (MAX_CHAINS),
    .CONFIG_ID (PERSONAL_CONFIG_ID)
  ) u_loader (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (!tracing),
    .config_id_i   (configId),
    .config_data_i (configData),
    .regs_o        (modes)
  );

  vec_t               buf_q, buf_d;
  logic [LANES_W-1:0] fill_q, fill_d, new_fill;
  logic [CHAIN_W-1:0] pack_chain_q, pack_chain_d;
  logic [1:0]         pack_eof_q, pack_eof_d;

  logic               emit, drop;
  vec_t               emit_buf;
  logic [LANES_W-1:0] emit_lanes;
  logic [CHAIN_W-1:0] emit_chain;
  logic [1:0]         emit_eof;
  mode_t              mode;

  vec_t               vec_q, vec_d;
  logic               valid_q;
  logic [CHAIN_W-1:0] chain_q;
  logic [1:0]         eof_q;
  logic [LANES_W-1:0] lanes_q;

  // Pack/pass decision; a chain switch emits the old partial and keeps the
  // new scalar buffered even if it carries a flush eof (one word per cycle)
  always_comb begin
    buf_d        = buf_q;
    fill_d       = fill_q;
    pack_chain_d = pack_chain_q;
    pack_eof_d   = pack_eof_q;
    emit         = 1'b0;
    emit_buf     = buf_q;
    emit_lanes   = '0;
    emit_chain   = '0;
    emit_eof     = '0;
    drop         = 1'b0;
    mode         = modes[bus.chainId_in];
    new_fill     = fill_q + LANES_W'(1);
    if (!tracing) begin
      fill_d = '0;
    end else if (bus.valid_in) begin
      if (!mode[MODE_SCALAR_BIT]) begin
        emit       = 1'b1;
        emit_buf   = bus.vector_in;
        emit_lanes = LANES_W'(N);
        emit_chain = bus.chainId_in;
        emit_eof   = bus.eof_in;
        if (fill_q != '0) begin
          drop   = 1'b1;
          fill_d = '0;
        end
      end else if ((fill_q != '0) && (bus.chainId_in != pack_chain_q)) begin
        emit         = 1'b1;
        emit_buf     = buf_q;
        emit_lanes   = fill_q;
        emit_chain   = pack_chain_q;
        emit_eof     = pack_eof_q;
        buf_d[0]     = bus.vector_in[0];
        fill_d       = LANES_W'(1);
        pack_chain_d = bus.chainId_in;
        pack_eof_d   = bus.eof_in;
      end else begin
        buf_d[fill_q[IDX_W-1:0]] = bus.vector_in[0];
        pack_chain_d = bus.chainId_in;
        pack_eof_d   = bus.eof_in;
        if ((new_fill == LANES_W'(N)) || (mode[MODE_FLUSH_BIT] && bus.eof_in[0])) begin
          emit       = 1'b1;
          emit_buf   = buf_d;
          emit_lanes = new_fill;
          emit_chain = bus.chainId_in;
          emit_eof   = bus.eof_in;
          fill_d     = '0;
        end else begin
          fill_d = new_fill;
        end
      end
    end
  end

  // Zero every lane beyond the meaningful count
  always_comb begin
    vec_d = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (emit && (LANES_W'(i) < emit_lanes)) begin
        vec_d[i] = emit_buf[i];
      end
    end
  end

  // Pack state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q        <= '0;
      fill_q       <= '0;
      pack_chain_q <= '0;
      pack_eof_q   <= '0;
      vec_q        <= '0;
      valid_q      <= 1'b0;
      chain_q      <= '0;
      eof_q        <= '0;
      lanes_q      <= '0;
    end else begin
      buf_q        <= buf_d;
      fill_q       <= fill_d;
      pack_chain_q <= pack_chain_d;
      pack_eof_q   <= pack_eof_d;
      vec_q        <= vec_d;
      valid_q      <= emit;
      chain_q      <= emit_chain;
      eof_q        <= emit_eof;
      lanes_q      <= emit_lanes;
    end
  end

  assign bus.vector_out  = vec_q;
  assign bus.valid_out   = valid_q;
  assign bus.chainId_out = chain_q;
  assign bus.eof_out     = eof_q;
  assign bus.lanes_out   = lanes_q;

`ifdef DATA_PACKER_DROP_CNT_EN
  logic        tracing_q;
  logic [15:0] drop_cnt_q;

  // Saturating count of partial packs discarded by pass vectors in trace mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tracing_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      tracing_q <= tracing;
      if (tracing && !tracing_q) begin
        drop_cnt_q <= '0;
      end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign drop_count = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  // bof is carried on the bus but not needed here; mode bits 7:2 are reserved
  logic unused_bits;
  assign unused_bits = ^{bus.bof_in, modes};

endmodule

// File: tb/tb_data_packer.sv
// Self-checking bench for data_packer: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_data_packer;
  import data_packer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tracing = 1'b0;
  logic [7:0] configId = 8'hFF;
  logic [7:0] configData = 8'h00;
  logic       chk_en = 1'b0;

  data_packer_if bus();

`ifdef DATA_PACKER_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  data_packer #(.PERSONAL_CONFIG_ID(8'd0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tracing    (tracing),
    .configId   (configId),
    .configData (configData),
    .bus        (bus)
`ifdef DATA_PACKER_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  lane_t              m_q[$];
  int                 m_chain;
  logic [1:0]         m_eof;
  logic [7:0]         m_mode[MAX_CHAINS];
  int                 m_bc;
  int                 m_drops;
  logic               m_prev_tr;

  logic               e_valid;
  vec_t               e_vec;
  logic [CHAIN_W-1:0] e_chain;
  logic [1:0]         e_eof;
  logic [LANES_W-1:0] e_lanes;

  function automatic vec_t q2v();
    vec_t v = '0;
    foreach (m_q[i]) v[i] = m_q[i];
    return v;
  endfunction

  task automatic put(input vec_t v, input int n, input int c, input logic [1:0] ef);
    e_valid = 1'b1;
    e_chain = CHAIN_W'(c);
    e_eof   = ef;
    e_lanes = LANES_W'(n);
    e_vec   = '0;
    for (int i = 0; i < n; i++) e_vec[i] = v[i];
  endtask

  task automatic model_step();
    logic [7:0] md;
    int c;
    e_valid = 1'b0; e_vec = '0; e_chain = '0; e_eof = '0; e_lanes = '0;
    if (tracing && !m_prev_tr) m_drops = 0;
    m_prev_tr = tracing;
    if (!tracing) begin
      m_q.delete();
      if (configId == 8'd0) begin
        if (m_bc < MAX_CHAINS) m_mode[m_bc] = configData;
        if (m_bc < 255) m_bc++;
      end else begin
        m_bc = 0;
      end
    end else begin
      m_bc = 0;
      if (bus.valid_in) begin
        c  = int'(bus.chainId_in);
        md = m_mode[c];
        if (!md[0]) begin
          if (m_q.size() > 0) begin
            m_q.delete();
            if (m_drops < 65535) m_drops++;
          end
          put(bus.vector_in, N, c, bus.eof_in);
        end else if (m_q.size() > 0 && c != m_chain) begin
          put(q2v(), m_q.size(), m_chain, m_eof);
          m_q.delete();
          m_q.push_back(bus.vector_in[0]);
          m_chain = c;
          m_eof   = bus.eof_in;
        end else begin
          m_q.push_back(bus.vector_in[0]);
          m_chain = c;
          m_eof   = bus.eof_in;
          if (m_q.size() == N || (md[1] && bus.eof_in[0])) begin
            put(q2v(), m_q.size(), c, bus.eof_in);
            m_q.delete();
          end
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_chain = 0; m_eof = '0; m_bc = 0; m_drops = 0; m_prev_tr = 1'b0;
      foreach (m_mode[i]) m_mode[i] = 8'h00;
      e_valid = 1'b0; e_vec = '0; e_chain = '0; e_eof = '0; e_lanes = '0;
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid_out",   256'(bus.valid_out),   256'(e_valid));
      chk("vector_out",  bus.vector_out,        e_vec);
      chk("chainId_out", 256'(bus.chainId_out), 256'(e_chain));
      chk("eof_out",     256'(bus.eof_out),     256'(e_eof));
      chk("lanes_out",   256'(bus.lanes_out),   256'(e_lanes));
`ifdef DATA_PACKER_DROP_CNT_EN
      chk("drop_count",  256'(drop_count),      256'(16'(m_drops)));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < int'(N); i++) v[i] = lane_t'($urandom);
    return v;
  endfunction

  task automatic drive(input logic [CHAIN_W-1:0] c, input logic [1:0] ef, input vec_t v);
    bus.valid_in   = 1'b1;
    bus.chainId_in = c;
    bus.eof_in     = ef;
    bus.bof_in     = 2'($urandom);
    bus.vector_in  = v;
    @(negedge clk);
  endtask

  task automatic sc(input logic [CHAIN_W-1:0] c, input logic [1:0] ef, input lane_t l0);
    vec_t v;
    v    = rand_vec();
    v[0] = l0;
    drive(c, ef, v);
  endtask

  task automatic idle();
    bus.valid_in   = 1'b0;
    bus.chainId_in = CHAIN_W'($urandom);
    bus.eof_in     = 2'($urandom);
    bus.vector_in  = rand_vec();
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3, input int extra);
    logic [7:0] b[4];
    b = '{b0, b1, b2, b3};
    tracing  = 1'b0;
    configId = 8'h5A;
    bus.valid_in  = 1'($urandom);
    bus.vector_in = rand_vec();
    @(negedge clk);
    for (int i = 0; i < 4 + extra; i++) begin
      configId      = 8'h00;
      configData    = (i < 4) ? b[i] : 8'($urandom);
      bus.valid_in  = 1'($urandom);
      bus.vector_in = rand_vec();
      @(negedge clk);
    end
    configId     = 8'hFF;
    bus.valid_in = 1'b0;
    @(negedge clk);
    tracing = 1'b1;
    @(negedge clk);
  endtask

  function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3,
                              input int a4, input int a5, input int a6, input int a7);
    vec_t v;
    v[0] = lane_t'(a0); v[1] = lane_t'(a1); v[2] = lane_t'(a2); v[3] = lane_t'(a3);
    v[4] = lane_t'(a4); v[5] = lane_t'(a5); v[6] = lane_t'(a6); v[7] = lane_t'(a7);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    vec_t v;
    bus.valid_in = 1'b0; bus.eof_in = '0; bus.bof_in = '0;
    bus.chainId_in = '0; bus.vector_in = '0;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    #2;
    chk("reset_valid", 256'(bus.valid_out), 256'(0));
    chk("reset_vec",   bus.vector_out,      256'(0));
    chk("reset_lanes", 256'(bus.lanes_out), 256'(0));
    @(negedge clk); @(negedge clk);
    rst_n   = 1'b1;
    tracing = 1'b1;
    @(negedge clk);

    // Pass mode, chain 0
    v = mk(1, 2, 3, 4, 5, 6, 7, 8);
    drive(2'd0, 2'b00, v);
    chk("pass_valid", 256'(bus.valid_out), 256'(1));
    chk("pass_vec",   bus.vector_out, mk(1, 2, 3, 4, 5, 6, 7, 8));
    chk("pass_lanes", 256'(bus.lanes_out), 256'(8));
    idle();

    // Eight scalars fill one word
    load(8'd1, 8'd0, 8'd0, 8'd0, 0);
    for (int i = 0; i < 8; i++) begin
      sc(2'd0, 2'b00, lane_t'(10 + i));
      if (i < 7) chk("pack_early_valid", 256'(bus.valid_out), 256'(0));
    end
    chk("pack_valid", 256'(bus.valid_out), 256'(1));
    chk("pack_vec",   bus.vector_out, mk(10, 11, 12, 13, 14, 15, 16, 17));
    chk("pack_lanes", 256'(bus.lanes_out), 256'(8));
    idle();

    // Flush on eof
    load(8'd3, 8'd0, 8'd0, 8'd0, 0);
    sc(2'd0, 2'b00, 32'd5);
    sc(2'd0, 2'b00, 32'd6);
    sc(2'd0, 2'b01, 32'd7);
    chk("flush_valid", 256'(bus.valid_out), 256'(1));
    chk("flush_vec",   bus.vector_out, mk(5, 6, 7, 0, 0, 0, 0, 0));
    chk("flush_lanes", 256'(bus.lanes_out), 256'(3));
    chk("flush_eof",   256'(bus.eof_out), 256'(1));
    idle();

    // Chain switch
    load(8'd1, 8'd1, 8'd0, 8'd0, 0);
    sc(2'd0, 2'b00, 32'd4);
    sc(2'd0, 2'b00, 32'd5);
    sc(2'd1, 2'b00, 32'd9);
    chk("switch_vec",   bus.vector_out, mk(4, 5, 0, 0, 0, 0, 0, 0));
    chk("switch_chain", 256'(bus.chainId_out), 256'(0));
    chk("switch_lanes", 256'(bus.lanes_out), 256'(2));
    for (int i = 0; i < 7; i++) sc(2'd1, 2'b00, lane_t'(100 + i));
    chk("switch_full_vec",   bus.vector_out, mk(9, 100, 101, 102, 103, 104, 105, 106));
    chk("switch_full_chain", 256'(bus.chainId_out), 256'(1));
    idle();

    // Pass vector collides with a partial pack
    load(8'd1, 8'd0, 8'd0, 8'd0, 0);
    sc(2'd0, 2'b00, 32'd1);
    sc(2'd0, 2'b00, 32'd2);
    v = mk(20, 21, 22, 23, 24, 25, 26, 27);
    drive(2'd1, 2'b00, v);
    chk("coll_vec",   bus.vector_out, mk(20, 21, 22, 23, 24, 25, 26, 27));
    chk("coll_chain", 256'(bus.chainId_out), 256'(1));
`ifdef DATA_PACKER_DROP_CNT_EN
    chk("coll_drop", 256'(drop_count), 256'(1));
`endif
    idle();

    // Asynchronous reset mid-pack
    load(8'd1, 8'd0, 8'd0, 8'd0, 2);
    for (int i = 0; i < 5; i++) sc(2'd0, 2'b00, lane_t'(50 + i));
    bus.valid_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 256'(bus.valid_out), 256'(0));
    chk("arst_vec",   bus.vector_out,      256'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load(8'd1, 8'd0, 8'd0, 8'd0, 0);
    for (int i = 0; i < 8; i++) sc(2'd0, 2'b00, lane_t'(60 + i));
    chk("arst_full_vec",   bus.vector_out, mk(60, 61, 62, 63, 64, 65, 66, 67));
    chk("arst_full_lanes", 256'(bus.lanes_out), 256'(8));
    idle();

    // Random traffic with periodic reconfiguration
    for (int r = 0; r < 6; r++) begin
      load(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3));
      for (int k = 0; k < 300; k++) begin
        if ($urandom_range(0, 9) < 7) drive(CHAIN_W'($urandom), 2'($urandom), rand_vec());
        else idle();
      end
    end
    idle(); idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_packer.md
Name: data_packer

Overview:
- Downstream neighbour of the vector-vector ALU.
- Consumes ALU result vectors tagged with chainId/eof/bof and feeds the trace buffer.
- Per-chain firmware selects one of two modes:
  - pass: the whole vector goes through.
  - scalar-pack: lane 0 of successive vectors is collected into one N-lane output vector, so reduced results fill trace-buffer words densely.

Parameters:
- N, 8, lanes per vector.
- DATA_WIDTH, 32, bits per lane.
- MAX_CHAINS, 4, number of firmware chains.
- PERSONAL_CONFIG_ID, 0, configId value that addresses this block.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- tracing  in  1  1 = trace mode; 0 = config mode
- valid_in  in  1  input vector valid
- eof_in  in  2  end-of-frame flags
- bof_in  in  2  begin-of-frame flags
- chainId_in  in  $clog2(MAX_CHAINS)  chain tag
- configId  in  8  config target id
- configData  in  8  config byte
- vector_in  in  N x DATA_WIDTH  input lanes
- vector_out  out  N x DATA_WIDTH  output lanes
- valid_out  out  1  output valid, one-cycle pulse per word
- chainId_out  out  $clog2(MAX_CHAINS)  chain of the emitted word
- eof_out  out  2  eof of the last contributing input
- lanes_out  out  $clog2(N)+1  number of meaningful lanes (N in pass mode)

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0.
  - fill=0, pack_chain=0, byte_counter=0.
  - Firmware mode regs = 0 (pass, no flush).
- Firmware byte per chain: bit0 = scalar-pack, bit1 = flush-on-eof[0]. Other bits are ignored.
- Config mode (tracing=0):
  - valid_out=0.
  - fill is cleared and any partial pack is discarded silently.
  - While configId==PERSONAL_CONFIG_ID: mode[byte_counter] <= configData for byte_counter<MAX_CHAINS, then byte_counter++. Bytes beyond MAX_CHAINS are ignored; the counter saturates at 255.
  - byte_counter returns to 0 when configId differs.
- Trace mode, all outputs registered, latency 1 cycle.
- Pass mode input:
  - vector_out=vector_in, lanes_out=N, chainId/eof copied, valid_out=1.
- Scalar-pack input, with chain c:
  - If fill>0 and c!=pack_chain: emit the partial buffer this cycle (chainId_out=pack_chain, lanes_out=fill), then store the new lane 0 at index 0 with fill=1 and pack_chain=c.
  - Else: store vector_in[0] at buf[fill], fill++, pack_chain=c.
  - If the new fill reaches N: emit the full buffer (lanes_out=N) and set fill=0.
  - Else if flush bit set and eof_in[0]=1: emit the partial buffer (lanes_out=fill) and set fill=0.
  - The full and eof conditions in the same cycle produce exactly one emission.
- Pass-mode input while fill>0: the pass vector owns the output. The partial pack is discarded, fill=0, and a drop event is recorded (see Optional Feature).
- Lanes at index >= lanes_out are driven 0.
- valid_in=0: no state change, valid_out=0.
- Reset asserted mid-pack: the partial data is lost and no emission occurs.

Optional Feature:
- Macro DATA_PACKER_DROP_CNT_EN.
- Defined:
  - Extra output port drop_count, 16 bits, reset 0.
  - Increments saturating on each discarded partial pack in trace mode.
  - Config-mode discards are not counted.
  - Clears to 0 when tracing rises 0->1.
- Undefined: no port and no counter logic; drops are silent.

Decomposition:
- Package data_packer_pkg:
  - MODE_SCALAR_BIT=0, MODE_FLUSH_BIT=1.
  - typedef lane_t (DATA_WIDTH logic).
  - typedef mode_t (8-bit).
- Sub-module config_byte_loader: the byte_counter/configId matching loader writing a MAX_CHAINS x 8 register array. It is reusable by other firmware-programmed stages.
- The packing datapath stays in the top module.

Test Plan (N=8):
- Pass mode, chain 0: vector_in = 1..8, valid one cycle -> next cycle valid_out=1, vector_out = 1..8, lanes_out=8.
- Config then pack:
  - Load mode bytes {1,0,0,0}.
  - Send 8 chain-0 vectors with lane0 = 10..17.
  - Expect exactly one valid_out after the 8th, vector_out = 10..17, lanes_out=8.
- Flush on eof:
  - Mode byte 3.
  - Send 3 vectors with lane0 = 5,6,7, eof_in[0]=1 on the 3rd.
  - Expect valid_out with lanes {5,6,7,0,0,0,0,0}, lanes_out=3.
- Chain switch:
  - Modes {1,1,0,0}.
  - Send chain0 lane0 = 4,5, then chain1 lane0 = 9.
  - Expect emission {4,5,0...}, chainId_out=0, lanes_out=2; then fill=1 for chain 1.
- Pass collision:
  - Modes {1,0,0,0}.
  - Send 2 chain-0 scalars, then chain-1 vector 20..27.
  - Expect output 20..27 only; drop_count=1 when DATA_PACKER_DROP_CNT_EN is defined.
- Async reset:
  - Assert rst_n=0 mid-pack with fill=5 -> outputs 0 immediately.
  - After release, 8 new scalars produce one full word with no stale lanes.
